// File: rtl/pulse_burst_scheduler.sv
// pulse_burst_scheduler: round-robin arbiter in front of one shared pulse
// sequencer. The winner's dur/per/cnt are captured at grant; the burst is
// validated, played out as cnt frames of dur-high / (per-dur)-low, and closed
// with a one-cycle done strobe carrying err/aborted status.
module pulse_burst_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*COUNTER_WIDTH-1:0] dur,
  input  logic [NUM_REQ*COUNTER_WIDTH-1:0] per,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]     cnt,
  input  logic                             abort,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               done,
  output logic                             err,
  output logic                             aborted,
  output logic                             pulse,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       active_id
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = COUNTER_WIDTH;
  localparam int NW  = CNT_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_HIGH, S_LOW, S_FIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr, w_ptr_nxt;
  logic [IDW-1:0]  r_id, w_id_nxt;
  logic [CW-1:0]   r_dur, w_dur_nxt;
  logic [CW-1:0]   r_per, w_per_nxt;
  logic [NW-1:0]   r_cnt, w_cnt_nxt;
  logic [NW-1:0]   r_rem, w_rem_nxt;
  logic [CW-1:0]   r_phase, w_phase_nxt;
  logic            r_err, w_err_nxt;
  logic            r_abt, w_abt_nxt;
  logic            r_pulse;

  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [CW-1:0]   w_low;
  logic            w_invalid;
  logic [NUM_REQ-1:0] w_onehot;

  assign w_low     = r_per - r_dur;
  assign w_invalid = (r_dur == '0) || (r_per <= r_dur) || (r_cnt == '0);
  assign w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_id;

  // Round-robin pick: the first set req bit at or above the pointer, wrapping.
  // Scanning offsets high-to-low lets the smallest offset win the last write.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        w_any = 1'b1;
        w_win = IDW'(idx);
      end
    end
  end

  // Next-state and datapath update; abort beats validation and natural end.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_dur_nxt   = r_dur;
    w_per_nxt   = r_per;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_phase_nxt = r_phase;
    w_err_nxt   = r_err;
    w_abt_nxt   = r_abt;
    case (r_state)
      S_IDLE: begin
        w_err_nxt = 1'b0;
        w_abt_nxt = 1'b0;
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_id_nxt    = w_win;
          w_dur_nxt   = dur[w_win*CW +: CW];
          w_per_nxt   = per[w_win*CW +: CW];
          w_cnt_nxt   = cnt[w_win*NW +: NW];
        end
      end
      S_GRANT: begin
        if (abort) begin
          w_state_nxt = S_FIN;
          w_abt_nxt   = 1'b1;
        end else if (w_invalid) begin
          w_state_nxt = S_FIN;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_HIGH;
          w_phase_nxt = CW'(1);
          w_rem_nxt   = r_cnt;
        end
      end
      S_HIGH: begin
        if (abort) begin
          w_state_nxt = S_FIN;
          w_abt_nxt   = 1'b1;
        end else if (r_phase == r_dur) begin
          w_state_nxt = S_LOW;
          w_phase_nxt = CW'(1);
        end else begin
          w_phase_nxt = r_phase + CW'(1);
        end
      end
      S_LOW: begin
        if (abort) begin
          w_state_nxt = S_FIN;
          w_abt_nxt   = 1'b1;
        end else if (r_phase == w_low) begin
          w_rem_nxt   = r_rem - NW'(1);
          w_phase_nxt = CW'(1);
          w_state_nxt = (r_rem == NW'(1)) ? S_FIN : S_HIGH;
        end else begin
          w_phase_nxt = r_phase + CW'(1);
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + IDW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset kills any burst without a done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_dur   <= '0;
      r_per   <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_phase <= '0;
      r_err   <= 1'b0;
      r_abt   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_dur   <= w_dur_nxt;
      r_per   <= w_per_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_phase <= w_phase_nxt;
      r_err   <= w_err_nxt;
      r_abt   <= w_abt_nxt;
      r_pulse <= (w_state_nxt == S_HIGH);
    end
  end

  assign grant     = (r_state == S_GRANT) ? w_onehot : '0;
  assign done      = (r_state == S_FIN)   ? w_onehot : '0;
  assign err       = (r_state == S_FIN) & r_err;
  assign aborted   = (r_state == S_FIN) & r_abt;
  assign busy      = (r_state != S_IDLE);
  assign pulse     = r_pulse;
  assign active_id = r_id;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Bench for pulse_burst_scheduler: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model that predicts each
// burst from its grant cycle, frame arithmetic and end cycle.
module tb_pulse_burst_scheduler;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int NW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] dur = '0;
  logic [N*CW-1:0] per = '0;
  logic [N*NW-1:0] cnt = '0;
  logic            abort = 1'b0;
  logic [N-1:0]    grant, done;
  logic            err, aborted, pulse, busy;
  logic [1:0]      active_id;

  pulse_burst_scheduler #(.NUM_REQ(N), .COUNTER_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .req(req), .dur(dur), .per(per), .cnt(cnt),
    .abort(abort), .grant(grant), .done(done), .err(err), .aborted(aborted),
    .pulse(pulse), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int t = 0;

  // model: one burst described by grant cycle, end (done) cycle and config
  bit m_busy = 0;
  int m_g, m_end, m_w, m_dur, m_per, m_cnt;
  int m_ptr = 0;
  int m_aid = 0;
  bit m_err, m_abt;

  // scenario bookkeeping
  int gq[$];
  int gt[$];
  int pc;
  bit err_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic cfg(input int i, input int d, input int p, input int c);
    dur[i*CW +: CW] = CW'(d);
    per[i*CW +: CW] = CW'(p);
    cnt[i*NW +: NW] = NW'(c);
  endtask

  // advance the model across the edge that ends cycle t, using this cycle's inputs
  task automatic model_adv();
    if (!m_busy) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (req[i] && !m_busy) begin
            m_busy = 1;
            m_w    = i;
            m_aid  = i;
            m_g    = t + 1;
            m_dur  = int'(dur[i*CW +: CW]);
            m_per  = int'(per[i*CW +: CW]);
            m_cnt  = int'(cnt[i*NW +: NW]);
            m_abt  = 0;
            m_err  = !(m_dur != 0 && m_per > m_dur && m_cnt != 0);
            m_end  = m_err ? m_g + 1 : m_g + m_cnt * m_per + 1;
          end
        end
      end
    end else if (t < m_end && abort) begin
      m_end = t + 1;
      m_abt = 1;
      m_err = 0;
    end else if (t == m_end) begin
      m_ptr  = (m_w + 1) % N;
      m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, ed;
    logic ep, eb, ee, ea;
    int off;
    eg = '0; ed = '0; ep = 0; eb = 0; ee = 0; ea = 0;
    if (m_busy) begin
      eb  = 1;
      off = t - m_g;
      if (off == 0) eg = N'(1) << m_w;
      if (t == m_end) begin
        ed = N'(1) << m_w;
        ee = m_err;
        ea = m_abt;
      end else if (off >= 1 && m_per > 0 && ((off - 1) % m_per) < m_dur) begin
        ep = 1;
      end
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("done", 32'(done), 32'(ed));
    chk("err", 32'(err), 32'(ee));
    chk("aborted", 32'(aborted), 32'(ea));
    chk("pulse", 32'(pulse), 32'(ep));
    chk("busy", 32'(busy), 32'(eb));
    chk("active_id", 32'(active_id), 32'(m_aid));
  endtask

  task automatic tick();
    model_adv();
    @(posedge clk);
    #1;
    t++;
    check_outputs();
    if (pulse) pc++;
    if (done != '0 && err) err_seen = 1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    req = '0;
    while (m_busy && k < 200) begin
      tick();
      k++;
    end
    if (m_busy) chk("drain_timeout", 0, 1);
    tick();
  endtask

  // raise r, record grants until ng seen; drop a winner's bit unless hold
  task automatic run_req(input logic [N-1:0] r, input int ng, input bit hold);
    int k;
    k = 0;
    gq.delete();
    gt.delete();
    pc = 0;
    err_seen = 0;
    req = r;
    while (gq.size() < ng && k < 400) begin
      tick();
      k++;
      if (grant != '0) begin
        for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
        gt.push_back(t);
        if (!hold) req = req & ~grant;
      end
    end
    if (gq.size() < ng) chk("grant_timeout", 32'(gq.size()), 32'(ng));
    drain();
  endtask

  initial begin
    int g, dat, ga;
    #12;
    check_outputs();
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;

    // single burst req[1] dur=2 per=5 cnt=3
    cfg(1, 2, 5, 3);
    req = 4'b0010;
    tick();
    chk("s1_grant", 32'(grant), 32'h2);
    req = '0;
    g = t; dat = -1; pc = 0;
    while (m_busy && t < g + 100) begin
      tick();
      if (done[1]) dat = t;
    end
    chk("s1_pulses", 32'(pc), 6);
    chk("s1_done_at", 32'(dat - g), 16);
    tick();

    // simultaneous req[0], req[2]; pointer now 2 -> 2 first, then 0
    cfg(0, 1, 2, 1); cfg(2, 1, 2, 1);
    run_req(4'b0101, 2, 0);
    chk("rr_a0", 32'(gq[0]), 2);
    chk("rr_a1", 32'(gq[1]), 0);
    // pointer now 1 -> 2 before 0 again; then a req[3] burst sets pointer 0
    run_req(4'b0101, 2, 0);
    chk("rr_b0", 32'(gq[0]), 2);
    chk("rr_b1", 32'(gq[1]), 0);
    cfg(3, 1, 2, 1);
    run_req(4'b1000, 1, 0);
    run_req(4'b0101, 2, 0);
    chk("rr_c0", 32'(gq[0]), 0);
    chk("rr_c1", 32'(gq[1]), 2);

    // invalid configurations: per<=dur, dur=0, cnt=0
    cfg(1, 5, 5, 2);
    run_req(4'b0010, 1, 0);
    chk("inv_a_err", 32'(err_seen), 1);
    chk("inv_a_pulse", 32'(pc), 0);
    cfg(1, 0, 5, 2);
    run_req(4'b0010, 1, 0);
    chk("inv_b_err", 32'(err_seen), 1);
    chk("inv_b_pulse", 32'(pc), 0);
    cfg(1, 2, 5, 0);
    run_req(4'b0010, 1, 0);
    chk("inv_c_err", 32'(err_seen), 1);
    chk("inv_c_pulse", 32'(pc), 0);

    // abort in second HIGH of dur=3 per=6 cnt=4; pointer is 2
    cfg(2, 3, 6, 4); cfg(3, 1, 2, 1);
    req = 4'b1100;
    tick();
    chk("ab_grant", 32'(grant), 32'h4);
    req = 4'b1000;
    ga = t;
    while (t < ga + 8) tick();
    chk("ab_pre_pulse", 32'(pulse), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_pulse", 32'(pulse), 0);
    chk("ab_flag", 32'(aborted), 1);
    chk("ab_done", 32'(done), 32'h4);
    tick();
    tick();
    chk("ab_next", 32'(grant), 32'h8);
    drain();

    // async reset during LOW
    cfg(1, 1, 4, 2);
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    tick();
    chk("rst_pre_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_pulse", 32'(pulse), 0);
    chk("rst_async_grant", 32'(grant), 0);
    chk("rst_async_done", 32'(done), 0);
    chk("rst_async_id", 32'(active_id), 0);
    m_busy = 0; m_ptr = 0; m_aid = 0;
    cfg(3, 1, 2, 1);
    req = 4'b1000;
    #2 rst = 1'b1;
    tick();
    chk("rst_first", 32'(grant), 32'h8);
    drain();

    // all four requesting continuously, dur=1 per=2 cnt=1
    for (int i = 0; i < N; i++) cfg(i, 1, 2, 1);
    run_req(4'b1111, 8, 1);
    for (int i = 0; i < 8; i++) chk("all_order", 32'(gq[i]), 32'(i % N));
    for (int i = 0; i < 7; i++) chk("all_gap", 32'(gt[i+1] - gt[i]), 5);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        cfg(i, $urandom_range(0, 4), $urandom_range(0, 8), $urandom_range(0, 3));
      req   = N'($urandom & $urandom);
      abort = ($urandom_range(0, 29) == 0);
      tick();
    end
    abort = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
